if_stage_fetch: RTL and testbench

//   Instruction-fetch stage of the 5-stage RV32 pipeline. It owns the PC register and

---
 rtl/if_stage_fetch.sv | 85 ++++++++
 tb/tb_if_stage_fetch.sv | 109 ++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, drives the imem address and loads the IF/ID buffer.
// A one-cycle BOOT state after reset delivers a bubble before the first real fetch.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_BOOT | first cycle after reset; PC holds, IF/ID loads a bubble
// ST_RUN  | normal fetch; priority flush > stall > advance; terminal
module if_stage_fetch #(
    parameter int               PC_W      = 9,
    parameter logic [PC_W-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [31:0]        imem_rdata_i,
    output logic [PC_W+31:0]   if_id_o,
    output logic               if_id_valid_o,
    output logic [31:0]        fetch_cnt_o
);

    typedef enum logic {ST_BOOT, ST_RUN} state_t;

    localparam logic [PC_W+31:0] BUBBLE = {{PC_W{1'b0}}, NOP_INSTR};

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W+31:0]    if_id_q, if_id_d;
    logic                valid_q, valid_d;
    logic [31:0]         cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if_id_d = if_id_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if_id_d = BUBBLE;
                valid_d = 1'b0;
            end
            ST_RUN: begin
                if (flush_i) begin
                    // Targets are word aligned; drop any stray low bits.
                    pc_d    = {redirect_pc_i[PC_W-1:2], 2'b00};
                    if_id_d = BUBBLE;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    pc_d    = pc_q + PC_W'(4);
                    if_id_d = {pc_q, imem_rdata_i};
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            if_id_q <= BUBBLE;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_id_o       = if_id_q;
    assign if_id_valid_o = valid_q;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch with a small combinational instruction memory.
module tb_if_stage_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [8:0]  redirect_pc_i = '0;
    logic [8:0]  imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [40:0] if_id_o;
    logic        if_id_valid_o;
    logic [31:0] fetch_cnt_o;

    logic [31:0] mem [128];
    int checks = 0;
    int errors = 0;

    localparam logic [40:0] BUB = {9'h000, 32'h0000_0013};

    if_stage_fetch dut (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .flush_i(flush_i),
        .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i), .if_id_o(if_id_o),
        .if_id_valid_o(if_id_valid_o), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;
    assign imem_rdata_i = mem[imem_addr_o[8:2]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string tag, input logic [8:0] pc, input logic [40:0] ifid,
                        input logic v, input logic [31:0] cnt);
        chk({tag, ".pc"},  64'(imem_addr_o), 64'(pc));
        chk({tag, ".ifid"}, 64'(if_id_o), 64'(ifid));
        chk({tag, ".vld"}, 64'(if_id_valid_o), 64'(v));
        chk({tag, ".cnt"}, 64'(fetch_cnt_o), 64'(cnt));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0A00_0000 + 32'(i);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;

        // 1: reset, boot bubble, first two fetches
        #12;
        look("rst", 9'h000, BUB, 1'b0, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        step(); look("boot", 9'h000, BUB, 1'b0, 32'd0);
        step(); look("f0", 9'h004, {9'h000, 32'h0050_0093}, 1'b1, 32'd1);
        step(); look("f4", 9'h008, {9'h004, 32'h0010_0113}, 1'b1, 32'd2);
        step(); look("f8", 9'h00C, {9'h008, 32'h0A00_0002}, 1'b1, 32'd3);
        step(); look("fC", 9'h010, {9'h00C, 32'h0A00_0003}, 1'b1, 32'd4);

        // 2: three-cycle stall at pc 0x10
        stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); look("stall", 9'h010, {9'h00C, 32'h0A00_0003}, 1'b1, 32'd4);
        end
        stall_i = 1'b0;
        step(); look("resume", 9'h014, {9'h010, 32'h0A00_0004}, 1'b1, 32'd5);

        // 3: flush wins over stall, low bits of target forced to zero
        flush_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 9'h043;
        step(); look("flush", 9'h040, BUB, 1'b0, 32'd5);
        flush_i = 1'b0; stall_i = 1'b0; redirect_pc_i = 9'h099;
        step(); look("f40", 9'h044, {9'h040, 32'h0A00_0010}, 1'b1, 32'd6);

        // 4: PC wrap at the top of the address space
        flush_i = 1'b1; redirect_pc_i = 9'h1FC;
        step(); look("to1FC", 9'h1FC, BUB, 1'b0, 32'd6);
        flush_i = 1'b0;
        step(); look("wrap", 9'h000, {9'h1FC, 32'h0A00_007F}, 1'b1, 32'd7);

        // 6: back-to-back flushes
        flush_i = 1'b1; redirect_pc_i = 9'h020;
        step(); look("fl20", 9'h020, BUB, 1'b0, 32'd7);
        redirect_pc_i = 9'h080;
        step(); look("fl80", 9'h080, BUB, 1'b0, 32'd7);
        flush_i = 1'b0;
        step(); look("f80", 9'h084, {9'h080, 32'h0A00_0020}, 1'b1, 32'd8);

        // 5: async reset mid-run under stall
        stall_i = 1'b1;
        step(); look("hold", 9'h084, {9'h080, 32'h0A00_0020}, 1'b1, 32'd8);
        #2 reset_n = 1'b0;
        #1 look("arst", 9'h000, BUB, 1'b0, 32'd0);
        stall_i = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        step(); look("boot2", 9'h000, BUB, 1'b0, 32'd0);
        step(); look("r0", 9'h004, {9'h000, 32'h0050_0093}, 1'b1, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
